// File: rtl/joy_db15_tx_pkg.sv
// Package joy_db15_pkg: button map, frame geometry and the load-image helper.
// Pure constants and types; no logic, no latency.
// Backpressure: none. The serial link is clocked entirely by the external reader.
package joy_db15_pkg;

  // One joystick state, bit map LS F E D C B A U D L R (bit0 = R).
  localparam int BTN_BITS   = 12;
  localparam int FRAME_BITS = 2 * BTN_BITS;

  localparam int BTN_R  = 0;
  localparam int BTN_L  = 1;
  localparam int BTN_DN = 2;
  localparam int BTN_UP = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_D  = 7;
  localparam int BTN_E  = 8;
  localparam int BTN_F  = 9;
  localparam int BTN_S  = 10;
  localparam int BTN_LS = 11;

  typedef logic [BTN_BITS-1:0]   btn_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  // Parallel-load image of the 74HC165 chain. The line is active-low, so a
  // pressed button becomes 0. Player 1 bit0 lands at the serial end (frame_t
  // bit0) and goes out first.
  function automatic frame_t frame_image(input btn_t p1, input btn_t p2);
    return ~{p2, p1};
  endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// DB15 serial link: two strobes from the reader and the data line back.
// Wires only; no latency.
// Backpressure: none. The reader paces the link with JOY_LOAD/JOY_CLK.
interface joy_db15_tx_if;

  logic JOY_LOAD;  // low = parallel load (SH/LD)
  logic JOY_CLK;   // rising edge advances one bit
  logic JOY_DATA;  // active-low serial data

  // Reader side drives the strobes and samples the data.
  modport master (
    output JOY_LOAD,
    output JOY_CLK,
    input  JOY_DATA
  );

  // Responder side (this block) receives the strobes and drives the data.
  modport slave (
    input  JOY_LOAD,
    input  JOY_CLK,
    output JOY_DATA
  );

endinterface

// File: rtl/joy_db15_tx_sync_edge.sv
// joy_sync_edge: 2-flop synchroniser for one async strobe, rise/fall pulses out.
// Latency: 2 clk to level, pulses in the same cycle; +1 with JOY_DB15_TX_GLITCH_FILTER_EN.
// Backpressure: none. Pulses are single-cycle and are never held.
module joy_sync_edge #(
  // Level assumed while in reset. Use the idle level of the strobe so that
  // leaving reset does not produce a false rising edge.
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Two-flop synchroniser. meta may go metastable; only sync is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
    end else begin
      meta <= async_in;
      sync <= meta;
    end
  end

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
  logic [1:0] hist;

  // Keep the previous two synchronised samples for the majority vote.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= {2{RST_VAL}};
    end else begin
      hist <= {hist[0], sync};
    end
  end

  // 2-of-3 majority: a one-cycle glitch never wins the vote, and a real
  // transition shows up one cycle after it reaches sync.
  assign level = (sync & hist[0]) | (sync & hist[1]) | (hist[0] & hist[1]);
`else
  assign level = sync;
`endif

  // Remember the last level so transitions turn into one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= RST_VAL;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: shifts two 12-button states out as an active-low 24-bit DB15 serial frame.
// Latency: JOY_DATA moves 3 clk after a JOY_CLK rise (4 with JOY_DB15_TX_GLITCH_FILTER_EN).
// Backpressure: none. The reader owns the pace; extra clocks shift in 1s and set overrun.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int FRAME_BITS   = joy_db15_pkg::FRAME_BITS,
  parameter int IDLE_TIMEOUT = 1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  btn_t                 joystick1,
  input  btn_t                 joystick2,
  joy_db15_tx_if.slave         link,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 link_active
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic load_lvl;
  logic load_rise;
  logic load_fall;
  logic sclk_lvl;
  logic sclk_rise;
  logic sclk_fall;

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  load_seen;
  logic                  do_shift;

  joy_sync_edge #(.RST_VAL(1'b1)) u_load_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (link.JOY_LOAD),
    .level    (load_lvl),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  joy_sync_edge #(.RST_VAL(1'b1)) u_clk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (link.JOY_CLK),
    .level    (sclk_lvl),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // Only the rising edge of the reader clock matters here.
  logic unused_sclk;
  assign unused_sclk = sclk_lvl ^ sclk_fall;

  // A shift needs load released; when release and a clock edge land in the
  // same cycle the release wins so the first bit is never skipped.
  assign do_shift = sclk_rise & load_lvl & ~load_rise;

  // Shift register: transparent parallel load while load is low, otherwise
  // advance toward bit0 and fill with released (1) bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '1;
    end else if (!load_lvl) begin
      shreg <= frame_image(joystick1, joystick2);
    end else if (do_shift) begin
      shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
    end
  end

  assign link.JOY_DATA = shreg[0];

  // Bit counter with frame completion pulse and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_lvl) begin
        // A load in mid-frame just restarts counting; an aborted frame
        // never reports completion.
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (do_shift) begin
        if (bit_cnt == CNT_LAST) begin
          frame_done <= 1'b1;
        end
        if (bit_cnt == CNT_FULL) begin
          overrun <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Link watchdog: restarts on every load falling edge, saturates at the
  // timeout so a dead link stays reported as dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt  <= IDLE_MAX;
      load_seen <= 1'b0;
    end else if (load_fall) begin
      idle_cnt  <= '0;
      load_seen <= 1'b1;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign link_active = load_seen & (idle_cnt < IDLE_MAX);

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: a reader drives load/clock frames, a queue-based scoreboard checks.
// Reader samples the data line 5 cycles after each strobe edge.
// Checks are queued by the stimulus and popped by an independent monitor.
module tb_joy_db15_tx;

  localparam int K_DATA  = 0;
  localparam int K_OVR   = 1;
  localparam int K_LINK  = 2;
  localparam int K_FDLVL = 3;
  localparam int K_FDCNT = 4;

  typedef struct {
    int kind;
    int exp;
  } chk_t;

  logic        clk;
  logic        reset;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic        frame_done;
  logic        overrun;
  logic        link_active;

  joy_db15_tx_if link_if ();

  joy_db15_tx #(.IDLE_TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .link        (link_if),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .link_active (link_active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Scoreboard state
  chk_t exp_q[$];
  chk_t item;
  logic chk_req;
  int   n_chk;
  int   n_pass;
  int   fd_seen;

  // Reference model: the frame is a list of line levels, consumed one per
  // reader clock; an empty list means the line idles released (1).
  int   mdl_bits[$];
  int   mdl_shifts;
  int   mdl_ovr;
  int   mdl_fd;
  int   mdl_seen;

  function automatic string kind_name(input int k);
    case (k)
      K_DATA:  return "joy_data";
      K_OVR:   return "overrun";
      K_LINK:  return "link_active";
      K_FDLVL: return "frame_done_level";
      default: return "frame_done_count";
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts frame_done pulses and drains the queue on each request.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_seen++;
      cmp("frame_done_with_data_high", int'(link_if.JOY_DATA), 1);
    end
    if (chk_req) begin
      while (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        case (item.kind)
          K_DATA:  cmp(kind_name(item.kind), int'(link_if.JOY_DATA), item.exp);
          K_OVR:   cmp(kind_name(item.kind), int'(overrun), item.exp);
          K_LINK:  cmp(kind_name(item.kind), int'(link_active), item.exp);
          K_FDLVL: cmp(kind_name(item.kind), int'(frame_done), item.exp);
          default: cmp(kind_name(item.kind), fd_seen, item.exp);
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int exp);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    exp_q.push_back(c);
  endtask

  task automatic flush();
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask

  function automatic int mdl_data();
    return (mdl_bits.size() > 0) ? mdl_bits[0] : 1;
  endfunction

  task automatic check_state(input bit with_link);
    push(K_DATA, mdl_data());
    push(K_OVR, mdl_ovr);
    push(K_FDCNT, mdl_fd);
    if (with_link) push(K_LINK, mdl_seen);
    flush();
  endtask

  task automatic mdl_shift();
    if (mdl_shifts == 23) mdl_fd++;
    if (mdl_shifts == 24) mdl_ovr = 1;
    else mdl_shifts++;
    if (mdl_bits.size() > 0) void'(mdl_bits.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    mdl_bits.delete();
    mdl_shifts = 0;
    mdl_ovr    = 0;
    mdl_seen   = 0;
  endtask

  task automatic do_load(input logic [11:0] a, input logic [11:0] b);
    joystick1 = a;
    joystick2 = b;
    link_if.JOY_LOAD = 1'b0;
    tick(6);
    link_if.JOY_LOAD = 1'b1;
    tick(6);
    mdl_bits.delete();
    for (int k = 0; k < 12; k++) mdl_bits.push_back(a[k] ? 0 : 1);
    for (int k = 0; k < 12; k++) mdl_bits.push_back(b[k] ? 0 : 1);
    mdl_shifts = 0;
    mdl_ovr    = 0;
    mdl_seen   = 1;
  endtask

  task automatic do_clock();
    link_if.JOY_CLK = 1'b1;
    tick(5);
    link_if.JOY_CLK = 1'b0;
    tick(5);
    mdl_shift();
  endtask

  task automatic clocks_checked(input int n);
    for (int i = 0; i < n; i++) begin
      do_clock();
      check_state(1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] ra;
    logic [11:0] rb;
    int          rn;

    chk_req    = 1'b0;
    n_chk      = 0;
    n_pass     = 0;
    fd_seen    = 0;
    mdl_fd     = 0;
    joystick1  = '0;
    joystick2  = '0;
    link_if.JOY_LOAD = 1'b1;
    link_if.JOY_CLK  = 1'b0;
    reset      = 1'b1;
    tick(3);
    do_reset();

    // Reset state
    push(K_FDLVL, 0);
    check_state(1'b1);

    // One pressed button at each end of the frame
    do_load(12'h001, 12'h800);
    check_state(1'b1);
    clocks_checked(24);

    // Everything released, clocked past the end of the frame
    do_load(12'h000, 12'h000);
    check_state(1'b0);
    clocks_checked(26);
    do_load(12'h000, 12'h000);
    check_state(1'b0);

    // Frame aborted by a new load after 10 clocks
    do_load(12'h010, 12'h000);
    clocks_checked(10);
    do_load(12'h010, 12'h000);
    check_state(1'b0);
    clocks_checked(24);

    // Reset in the middle of a frame, then a fresh frame
    do_load(12'hA5C, 12'h3F1);
    clocks_checked(12);
    do_reset();
    push(K_FDLVL, 0);
    check_state(1'b1);
    do_load(12'h5A3, 12'hC0E);
    check_state(1'b1);
    clocks_checked(24);

    // Randomised frames of random length
    for (int r = 0; r < 6; r++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rn = $urandom_range(0, 27);
      do_load(ra, rb);
      check_state(1'b0);
      clocks_checked(rn);
    end

    // One-cycle glitch on the reader clock
    do_load(12'h001, 12'($urandom));
    link_if.JOY_CLK = 1'b1;
    tick(1);
    link_if.JOY_CLK = 1'b0;
    tick(8);
`ifndef JOY_DB15_TX_GLITCH_FILTER_EN
    mdl_shift();
`endif
    check_state(1'b0);
    clocks_checked(2);

    // Link timeout (64 cycles in this build)
    do_reset();
    check_state(1'b1);
    do_load(12'h000, 12'h000);
    tick(50);
    push(K_LINK, 1);
    flush();
    tick(9);
    push(K_LINK, 0);
    flush();
    do_load(12'h000, 12'h000);
    push(K_LINK, 1);
    flush();

    tick(2);
    if (exp_q.size() != 0) begin
      cmp("queue_drained", exp_q.size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Responder-side model of the DB15 serial joystick adapter: it presents two 12-button joystick states as the active-low 24-bit shift-register stream that the core's DB15 reader clocks in over JOY_LOAD/JOY_CLK/JOY_DATA. It sits on the user-port side, either in a loop-back bench against the reader or in a bridge core that re-exports local controls to another MiSTer. It synchronises the externally driven strobes, snapshots inputs on load, shifts on clock edges, and reports frame completion, overrun and link activity.

## Interface
- FRAME_BITS, 24: serial frame length (2 x BTN_BITS).
- IDLE_TIMEOUT, 1048576: clk cycles without a load before link_active drops.
- clk  in  1  system clock, 40-50 MHz (CLK_JOY domain).
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- joystick1  in  12  player 1 buttons, active-high, bit map LS FEDCBAUDLR (bit0 = R).
- joystick2  in  12  player 2 buttons, same map.
- JOY_LOAD  in  1  async from reader; low = parallel load (74HC165 SH/LD semantics).
- JOY_CLK  in  1  async from reader; rising edge advances one bit.
- JOY_DATA  out  1  serial data, active-low (pressed = 0).
- frame_done  out  1  one-cycle pulse when bit FRAME_BITS-1 has been shifted past.
- overrun  out  1  sticky: more than FRAME_BITS shifts since last load; cleared by next load.
- link_active  out  1  high while loads arrive within IDLE_TIMEOUT.

## Operation
- JOY_LOAD and JOY_CLK each pass through a 2-flop synchroniser plus edge detector.
- While synchronised load is low: shift register continuously reloaded with ~{joystick2, joystick1}; bit_cnt = 0; overrun cleared; clock edges ignored.
- Frame order: JOY_DATA presents ~joystick1[0] after load; each JOY_CLK rise moves to next bit; joystick1[11] then joystick2[0..11].
- Shift fills from the serial end with 1 (released); after 24 shifts JOY_DATA stays 1.
- bit_cnt 0..FRAME_BITS, saturating. Shift with bit_cnt == FRAME_BITS-1 -> frame_done pulse. Shift with bit_cnt == FRAME_BITS -> overrun set.
- Load falling edge mid-frame: frame aborted, reload, no frame_done.
- Load rising edge and clock rising edge in same synchronised cycle: load release wins, no shift.
- Idle counter: cleared on every load falling edge; saturates at IDLE_TIMEOUT; link_active = counter < IDLE_TIMEOUT and at least one load seen since reset.
- Reset mid-frame: all state to reset values immediately.

## Timing
- Reset values: JOY_DATA=1, frame_done=0, overrun=0, link_active=0, shift register all ones, bit_cnt=0, idle counter = IDLE_TIMEOUT.
- JOY_DATA updates 3 clk cycles after an external JOY_CLK rise (2 sync + 1 register); 4 with filter.
- Load sampling: inputs captured every cycle load is low; value sent is the one of the last cycle before release is detected.
- Reader requirement: JOY_CLK/JOY_LOAD high and low widths >= 4 clk cycles (>= 6 with filter); reader must sample JOY_DATA >= 4 cycles after its own clock edge.
- frame_done asserted in the same cycle JOY_DATA switches to the post-frame 1.

## Configuration
- JOY_DB15_TX_GLITCH_FILTER_EN defined: each synchronised strobe passes a 3-sample majority filter before edge detection (+1 cycle latency; single-cycle glitches rejected).
- Not defined: edge detection directly on synchroniser output; single-cycle glitches produce edges.

## Structure
- Package joy_db15_pkg: BTN_BITS=12, FRAME_BITS default, button bit index constants (R,L,D,U,A..F,S,LS).
- Sub-module joy_sync_edge: synchroniser, optional majority filter, rise/fall pulses; instantiated for JOY_LOAD and JOY_CLK.

## Test plan
- joystick1=12'h001, joystick2=12'h800, load pulse then 24 clocks -> JOY_DATA sequence 0 then 22x1 then 0; frame_done once after 24th clock.
- All buttons released, 26 clocks after load -> JOY_DATA all 1, frame_done after 24th, overrun=1 after 25th; next load clears overrun.
- Load reasserted after 10 clocks with joystick1=12'h010 -> bit_cnt restarts, 5th bit 0, no frame_done for aborted frame.
- Reset asserted after 12 clocks -> JOY_DATA=1, outputs at reset values next cycle; next load starts fresh frame.
- No load for IDLE_TIMEOUT=64 (param override) cycles after one load -> link_active falls at cycle 64; next load raises it.
- Filter build: 1-cycle JOY_CLK glitch -> no shift; without macro -> one shift.
